// File: rtl/multicycle_datapath.sv
// -----------------------------------------------------------------------------
// multicycle_datapath
//   32-bit RV32I multicycle datapath, driven by the multicycle controller's
//   control bundle. Holds PC, OldPC, IR, the 32x32 register file and the
//   non-architectural Data/A/B/ALUOut registers. Drives one unified
//   instruction/data memory port.
//
// Ports
//   clk         clock, all state updates on rising edge
//   reset       synchronous, active-low reset
//   ImmSrc      immediate format (00 I, 01 S, 10 B, 11 J)
//   ALUSrcA     SrcA select (00 PC, 01 OldPC, 10 A, 11 zero)
//   ALUSrcB     SrcB select (00 B, 01 ImmExt, 10 4, 11 zero)
//   ResultSrc   Result select (00 ALUOut, 01 Data, 10 ALUResult, 11 zero)
//   AdrSrc      Adr select (0 PC, 1 Result)
//   ALUControl  ALU operation
//   IRWrite     load IR with ReadData and OldPC with PC
//   PCWrite     load PC with Result
//   RegWrite    write Result to rd = IR[11:7]
//   ReadData    memory read data
//   Adr         memory address
//   WriteData   store data (B register)
//   op/funct3/funct7b5  instruction fields back to the controller
//   Zero        ALUResult == 0
//
// Configuration
//   DATAPATH_XOR_SRL_EN  when defined, ALUControl 100/110/111 implement
//                        xor / logical right shift / arithmetic right shift;
//                        when undefined those codes give ALUResult = 0.
// -----------------------------------------------------------------------------
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ImmSrc,
  input  logic [1:0]  ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  ResultSrc,
  input  logic        AdrSrc,
  input  logic [2:0]  ALUControl,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic        RegWrite,
  input  logic [31:0] ReadData,
  output logic [31:0] Adr,
  output logic [31:0] WriteData,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic        Zero
);

  logic [31:0] pc, old_pc, ir, data, a, b, alu_out;
  logic [31:0] rf [0:31];

  logic [31:0] imm_ext, src_a, src_b, alu_result, result, rd1, rd2;
  logic [4:0]  rs1, rs2, rd;

  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd  = ir[11:7];

  // x0 is forced to read zero independently of its storage contents
  assign rd1 = (rs1 == 5'd0) ? 32'h0 : rf[rs1];
  assign rd2 = (rs2 == 5'd0) ? 32'h0 : rf[rs2];

  always_comb begin
    imm_ext = 32'h0;
    case (ImmSrc)
      2'b00:   imm_ext = {{20{ir[31]}}, ir[31:20]};
      2'b01:   imm_ext = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      2'b10:   imm_ext = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default: imm_ext = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    endcase
  end

  always_comb begin
    src_a = 32'h0;
    case (ALUSrcA)
      2'b00:   src_a = pc;
      2'b01:   src_a = old_pc;
      2'b10:   src_a = a;
      default: src_a = 32'h0;
    endcase
  end

  always_comb begin
    src_b = 32'h0;
    case (ALUSrcB)
      2'b00:   src_b = b;
      2'b01:   src_b = imm_ext;
      2'b10:   src_b = 32'd4;
      default: src_b = 32'h0;
    endcase
  end

  always_comb begin
    alu_result = 32'h0;
    case (ALUControl)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = {31'h0, $signed(src_a) < $signed(src_b)};
`ifdef DATAPATH_XOR_SRL_EN
      3'b100:  alu_result = src_a ^ src_b;
      3'b110:  alu_result = src_a >> src_b[4:0];
      3'b111:  alu_result = $signed(src_a) >>> src_b[4:0];
`endif
      default: alu_result = 32'h0;
    endcase
  end

  assign Zero = (alu_result == 32'h0);

  always_comb begin
    result = 32'h0;
    case (ResultSrc)
      2'b00:   result = alu_out;
      2'b01:   result = data;
      2'b10:   result = alu_result;
      default: result = 32'h0;
    endcase
  end

  // AdrSrc=1 gives a purely combinational ALUOut/Data -> Adr path
  assign Adr       = AdrSrc ? result : pc;
  assign WriteData = b;
  assign op        = ir[6:0];
  assign funct3    = ir[14:12];
  assign funct7b5  = ir[30];

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc      <= RESET_PC;
      old_pc  <= 32'h0;
      ir      <= 32'h0;
      data    <= 32'h0;
      a       <= 32'h0;
      b       <= 32'h0;
      alu_out <= 32'h0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else begin
      data    <= ReadData;
      a       <= rd1;
      b       <= rd2;
      alu_out <= alu_result;
      if (PCWrite) pc <= result;
      if (IRWrite) begin
        ir     <= ReadData;
        old_pc <= pc;
      end
      if (RegWrite && (rd != 5'd0)) rf[rd] <= result;
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// -----------------------------------------------------------------------------
// tb_multicycle_datapath
//   Directed instruction sequences followed by randomized control/data
//   stimulus. A behavioural model of the architectural state is advanced on
//   every rising edge; a compare process checks all DUT outputs against it on
//   every falling edge, and the directed part adds literal expectations.
// -----------------------------------------------------------------------------
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic        AdrSrc;
  logic [2:0]  ALUControl;
  logic        IRWrite, PCWrite, RegWrite;
  logic [31:0] ReadData;
  logic [31:0] Adr, WriteData;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, Zero;

  multicycle_datapath #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .AdrSrc(AdrSrc),
    .ALUControl(ALUControl), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ReadData(ReadData), .Adr(Adr),
    .WriteData(WriteData), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic check_en = 1'b0;

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_old_pc, m_ir, m_data, m_a, m_b, m_alu_out;
  logic [31:0] m_rf [32];

  function automatic logic [31:0] m_imm();
    int v;
    case (ImmSrc)
      2'b00: v = int'($signed(m_ir[31:20]));
      2'b01: v = int'($signed({m_ir[31:25], m_ir[11:7]}));
      2'b10: v = int'($signed({m_ir[31], m_ir[7], m_ir[30:25], m_ir[11:8], 1'b0}));
      default: v = int'($signed({m_ir[31], m_ir[19:12], m_ir[20], m_ir[30:21], 1'b0}));
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_alu();
    logic [31:0] x, y;
    int sx, sy;
    x = (ALUSrcA == 2'd0) ? m_pc : (ALUSrcA == 2'd1) ? m_old_pc :
        (ALUSrcA == 2'd2) ? m_a : 32'h0;
    y = (ALUSrcB == 2'd0) ? m_b : (ALUSrcB == 2'd1) ? m_imm() :
        (ALUSrcB == 2'd2) ? 32'd4 : 32'h0;
    sx = x;
    sy = y;
    case (ALUControl)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd5: return (sx < sy) ? 32'h1 : 32'h0;
`ifdef DATAPATH_XOR_SRL_EN
      3'd4: return x ^ y;
      3'd6: return x >> y[4:0];
      3'd7: return sx >>> y[4:0];
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_result();
    case (ResultSrc)
      2'd0: return m_alu_out;
      2'd1: return m_data;
      2'd2: return m_alu();
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_reg(input logic [4:0] i);
    return (i == 5'd0) ? 32'h0 : m_rf[i];
  endfunction

  task automatic model_step();
    logic [31:0] res, na, nb, nalu;
    if (!reset) begin
      m_pc = 32'h0; m_old_pc = 0; m_ir = 0; m_data = 0; m_a = 0; m_b = 0; m_alu_out = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    end else begin
      res  = m_result();
      nalu = m_alu();
      na   = m_reg(m_ir[19:15]);
      nb   = m_reg(m_ir[24:20]);
      if (RegWrite && m_ir[11:7] != 5'd0) m_rf[m_ir[11:7]] = res;
      if (IRWrite) begin m_old_pc = m_pc; m_ir = ReadData; end
      if (PCWrite) m_pc = res;
      m_data = ReadData; m_a = na; m_b = nb; m_alu_out = nalu;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_adr", Adr, AdrSrc ? m_result() : m_pc);
      chk("m_wdata", WriteData, m_b);
      chk("m_op", {25'h0, op}, {25'h0, m_ir[6:0]});
      chk("m_funct3", {29'h0, funct3}, {29'h0, m_ir[14:12]});
      chk("m_f7b5", {31'h0, funct7b5}, {31'h0, m_ir[30]});
      chk("m_zero", {31'h0, Zero}, {31'h0, m_alu() == 32'h0});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic ctl(input logic [1:0] asa, input logic [1:0] asb, input logic [1:0] rsrc,
                     input logic adrs, input logic [2:0] alc, input logic [1:0] imms,
                     input logic irw, input logic pcw, input logic rw);
    ALUSrcA = asa; ALUSrcB = asb; ResultSrc = rsrc; AdrSrc = adrs;
    ALUControl = alc; ImmSrc = imms; IRWrite = irw; PCWrite = pcw; RegWrite = rw;
  endtask

  task automatic idle();
    ctl(2'b11, 2'b11, 2'b10, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic show_a();
    ctl(2'b10, 2'b11, 2'b10, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [31:0] pc_exp);
    ReadData = instr;
    ctl(2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 2'b00, 1'b1, 1'b1, 1'b0);
    settle();
    chk("fetch_adr", Adr, pc_exp);
    cyc();
  endtask

  // lw rd, 0x40(x0) with memory returning val
  task automatic load_rd(input logic [4:0] rd, input logic [31:0] val, input logic [31:0] pc_exp);
    fetch(32'h0400_2003 | {20'h0, rd, 7'h0}, pc_exp);
    ctl(2'b11, 2'b01, 2'b10, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
    settle();
    chk("load_addr_alu", Adr, 32'h40);
    cyc();
    ctl(2'b11, 2'b11, 2'b00, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
    ReadData = val;
    settle();
    chk("load_adr_aluout", Adr, 32'h40);
    cyc();
    ctl(2'b11, 2'b11, 2'b01, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1);
    settle();
    chk("load_wb_data", Adr, val);
    cyc();
  endtask

  initial begin
    reset = 1'b0;
    ReadData = 32'h0;
    idle();
    cyc();
    check_en = 1'b1;
    cyc();
    reset = 1'b1;
    settle();
    chk("rst_op", {25'h0, op}, 32'h0);
    chk("rst_funct3", {29'h0, funct3}, 32'h0);
    chk("rst_f7b5", {31'h0, funct7b5}, 32'h0);
    chk("rst_wdata", WriteData, 32'h0);

    // addi x1, x0, 5
    fetch(32'h0050_0093, 32'h0);
    ctl(2'b10, 2'b01, 2'b10, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
    settle();
    chk("addi_op", {25'h0, op}, 32'h13);
    chk("addi_funct3", {29'h0, funct3}, 32'h0);
    chk("addi_alu", Adr, 32'h5);
    cyc();
    ctl(2'b00, 2'b11, 2'b00, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1);
    settle();
    chk("addi_aluout", Adr, 32'h5);
    cyc();

    // addi x0, x1, 0 : reads x1 into A, then attempt to write x0
    fetch(32'h0000_8013, 32'h4);
    idle(); cyc();
    cyc();
    show_a();
    settle();
    chk("a_x1", Adr, 32'h5);
    cyc();
    idle();
    ReadData = 32'hDEAD_BEEF;
    cyc();
    ctl(2'b11, 2'b11, 2'b01, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1);
    settle();
    chk("x0_result", Adr, 32'hDEAD_BEEF);
    cyc();
    idle(); cyc();
    settle();
    chk("x0_read", WriteData, 32'h0);

    // x1 = x2 = 7, then beq x1, x2, -8 fetched at 0x10
    load_rd(5'd1, 32'd7, 32'h8);
    load_rd(5'd2, 32'd7, 32'hC);
    fetch(32'hFE20_8CE3, 32'h10);
    idle(); cyc();
    ctl(2'b10, 2'b00, 2'b10, 1'b1, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0);
    settle();
    chk("beq_zero", {31'h0, Zero}, 32'h1);
    chk("beq_wdata", WriteData, 32'h7);
    cyc();
    ctl(2'b01, 2'b01, 2'b10, 1'b1, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0);
    settle();
    chk("beq_target", Adr, 32'h8);
    cyc();

    // load path into x3, then read it back through A
    load_rd(5'd3, 32'h1234, 32'h14);
    fetch(32'h0001_8013, 32'h18);
    idle(); cyc();
    show_a();
    settle();
    chk("x3_read", Adr, 32'h1234);
    cyc();

    // x5 = 0x80000000; op 111 with SrcB = I-imm 4
    load_rd(5'd5, 32'h8000_0000, 32'h1C);
    fetch(32'h0042_8013, 32'h20);
    idle(); cyc();
    ctl(2'b10, 2'b01, 2'b10, 1'b1, 3'b111, 2'b00, 1'b0, 1'b0, 1'b0);
    settle();
`ifdef DATAPATH_XOR_SRL_EN
    chk("sra_result", Adr, 32'hF800_0000);
    chk("sra_zero", {31'h0, Zero}, 32'h0);
`else
    chk("op111_result", Adr, 32'h0);
    chk("op111_zero", {31'h0, Zero}, 32'h1);
`endif
    cyc();

    // reset overrides PCWrite and RegWrite
    reset = 1'b0;
    ctl(2'b11, 2'b01, 2'b10, 1'b1, 3'b000, 2'b00, 1'b0, 1'b1, 1'b1);
    cyc();
    reset = 1'b1;
    ctl(2'b11, 2'b11, 2'b10, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
    settle();
    chk("midrst_pc", Adr, 32'h0);
    chk("midrst_op", {25'h0, op}, 32'h0);
    chk("midrst_wdata", WriteData, 32'h0);
    fetch(32'h0001_8013, 32'h0);
    idle(); cyc();
    show_a();
    settle();
    chk("midrst_x3", Adr, 32'h0);
    cyc();

    // randomized control bundles and memory data
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 63) != 0);
      ImmSrc     = 2'($urandom_range(0, 3));
      ALUSrcA    = 2'($urandom_range(0, 3));
      ALUSrcB    = 2'($urandom_range(0, 3));
      ResultSrc  = 2'($urandom_range(0, 3));
      AdrSrc     = 1'($urandom_range(0, 1));
      ALUControl = 3'($urandom_range(0, 7));
      IRWrite    = ($urandom_range(0, 3) == 0);
      PCWrite    = ($urandom_range(0, 3) == 0);
      RegWrite   = ($urandom_range(0, 1) == 0);
      ReadData   = $urandom;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
